// File: rtl/iter_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide
// retiring BITS_PER_CYCLE bits per cycle, with valid/ready on both sides.
module iter_muldiv_unit #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int unsigned N  = XLEN / BITS_PER_CYCLE;
  localparam int unsigned CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t              state;
  logic [2:0]          op;
  logic                sign_a;
  logic                sign_b;
  logic [XLEN-1:0]     opnd;
  logic [2*XLEN-1:0]   prod;
  logic [CW-1:0]       count;

  logic                accept;
  logic                a_signed;
  logic                b_signed;
  logic                in_sa;
  logic                in_sb;
  logic                div_zero;
  logic                div_ovf;
  logic                special;
  logic [XLEN-1:0]     abs_a;
  logic [XLEN-1:0]     abs_b;
  logic [XLEN-1:0]     special_res;

  always_comb begin
    in_ready    = !flush && (state == IDLE || (state == DONE && out_ready));
    busy        = (state != IDLE);
    accept      = in_valid && in_ready;
    a_signed    = (funct3 != 3'b011) && (funct3 != 3'b101) && (funct3 != 3'b111);
    b_signed    = (funct3 == 3'b000) || (funct3 == 3'b001) ||
                  (funct3 == 3'b100) || (funct3 == 3'b110);
    in_sa       = a_signed && op_a[XLEN-1];
    in_sb       = b_signed && op_b[XLEN-1];
    abs_a       = in_sa ? -op_a : op_a;
    abs_b       = in_sb ? -op_b : op_b;
    div_zero    = funct3[2] && (op_b == '0);
    div_ovf     = funct3[2] && !funct3[0] &&
                  (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
    special     = div_zero || div_ovf;
    if (div_zero) special_res = funct3[1] ? op_a : '1;
    else          special_res = funct3[1] ? '0 : op_a;
  end

  // prod doubles as {partial product, remaining multiplier} for multiply and
  // {partial remainder, dividend/quotient} for divide; opnd is the multiplicand or divisor.
  logic [XLEN+BITS_PER_CYCLE-1:0] addend;
  logic [XLEN+BITS_PER_CYCLE-1:0] mul_sum;
  logic [XLEN:0]                  trial;
  logic [XLEN-1:0]                drem;
  logic [XLEN-1:0]                dquo;
  logic [2*XLEN-1:0]              step_next;

  always_comb begin
    addend = '0;
    for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
      if (prod[i]) addend = addend + ({{BITS_PER_CYCLE{1'b0}}, opnd} << i);
    end
    mul_sum = {{BITS_PER_CYCLE{1'b0}}, prod[2*XLEN-1:XLEN]} + addend;

    drem  = prod[2*XLEN-1:XLEN];
    dquo  = prod[XLEN-1:0];
    trial = '0;
    for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
      trial = {drem, dquo[XLEN-1]};
      if (trial >= {1'b0, opnd}) begin
        trial = trial - {1'b0, opnd};
        dquo  = {dquo[XLEN-2:0], 1'b1};
      end else begin
        dquo  = {dquo[XLEN-2:0], 1'b0};
      end
      drem = trial[XLEN-1:0];
    end

    if (op[2]) step_next = {drem, dquo};
    else       step_next = {mul_sum, prod[XLEN-1:BITS_PER_CYCLE]};
  end

  logic [2*XLEN-1:0] prod_neg;
  logic [XLEN-1:0]   quo_s;
  logic [XLEN-1:0]   rem_s;
  logic [XLEN-1:0]   fix_res;

  always_comb begin
    prod_neg = (sign_a ^ sign_b) ? -prod : prod;
    quo_s    = (sign_a ^ sign_b) ? -prod[XLEN-1:0] : prod[XLEN-1:0];
    rem_s    = sign_a ? -prod[2*XLEN-1:XLEN] : prod[2*XLEN-1:XLEN];
    case (op)
      3'b000:                 fix_res = prod_neg[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_res = prod_neg[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fix_res = quo_s;
      default:                fix_res = rem_s;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      op        <= '0;
      sign_a    <= 1'b0;
      sign_b    <= 1'b0;
      opnd      <= '0;
      prod      <= '0;
      count     <= '0;
      result    <= '0;
      out_valid <= 1'b0;
    end else if (flush) begin
      state     <= IDLE;
      out_valid <= 1'b0;
    end else if (accept) begin
      op     <= funct3;
      sign_a <= in_sa;
      sign_b <= in_sb;
      opnd   <= funct3[2] ? abs_b : abs_a;
      prod   <= {{XLEN{1'b0}}, (funct3[2] ? abs_a : abs_b)};
      count  <= '0;
      if (special) begin
        result    <= special_res;
        state     <= DONE;
        out_valid <= 1'b1;
      end else begin
        state     <= CALC;
        out_valid <= 1'b0;
      end
    end else begin
      case (state)
        CALC: begin
          prod  <= step_next;
          count <= count + 1'b1;
          if (count == LAST) state <= FIX;
        end
        FIX: begin
          result    <= fix_res;
          state     <= DONE;
          out_valid <= 1'b1;
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iter_muldiv_unit.sv
// Scoreboard bench for iter_muldiv_unit across three width/throughput configs
// (32/1, 16/2, 16/4); one config is steered at a time through shared stimulus.
module tb_iter_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        flush;
  logic        out_ready;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;

  logic iv0, iv1, iv2, ir0, ir1, ir2, ov0, ov1, ov2, bz0, bz1, bz2;
  logic [31:0] r0;
  logic [15:0] r1, r2;

  int          cfg;
  int unsigned w;
  int unsigned nsteps;
  logic [31:0] mask;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] sb_q[$];

  logic        obs_ready, obs_valid, obs_busy;
  logic [31:0] obs_res;

  always #5 clk = ~clk;

  assign iv0 = in_valid && (cfg == 0);
  assign iv1 = in_valid && (cfg == 1);
  assign iv2 = in_valid && (cfg == 2);
  assign obs_ready = (cfg == 0) ? ir0 : (cfg == 1) ? ir1 : ir2;
  assign obs_valid = (cfg == 0) ? ov0 : (cfg == 1) ? ov1 : ov2;
  assign obs_busy  = (cfg == 0) ? bz0 : (cfg == 1) ? bz1 : bz2;
  assign obs_res   = (cfg == 0) ? r0 : (cfg == 1) ? {16'h0, r1} : {16'h0, r2};

  iter_muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(1)) u0 (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .flush(flush), .out_valid(ov0),
    .out_ready(out_ready), .result(r0), .busy(bz0));
  iter_muldiv_unit #(.XLEN(16), .BITS_PER_CYCLE(2)) u1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .funct3(funct3),
    .op_a(op_a[15:0]), .op_b(op_b[15:0]), .flush(flush), .out_valid(ov1),
    .out_ready(out_ready), .result(r1), .busy(bz1));
  iter_muldiv_unit #(.XLEN(16), .BITS_PER_CYCLE(4)) u2 (
    .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .funct3(funct3),
    .op_a(op_a[15:0]), .op_b(op_b[15:0]), .flush(flush), .out_valid(ov2),
    .out_ready(out_ready), .result(r2), .busy(bz2));

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a32, b32, e32;
    logic [15:0] a16, b16, e16;
    bit          sp;
  } vec_t;

  vec_t vecs[13] = '{
    '{3'b000, 32'h7,        32'hFFFFFFFD, 32'hFFFFFFEB, 16'h7,    16'hFFFD, 16'hFFEB, 1'b0},
    '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b0},
    '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 16'h8000, 16'h8000, 16'h4000, 1'b0},
    '{3'b010, 32'hFFFFFFFF, 32'h2,        32'hFFFFFFFF, 16'hFFFF, 16'h2,    16'hFFFF, 1'b0},
    '{3'b000, 32'hFF,       32'h101,      32'hFFFF,     16'hFF,   16'h101,  16'hFFFF, 1'b0},
    '{3'b100, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFD, 16'hFFF9, 16'h2,    16'hFFFD, 1'b0},
    '{3'b110, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 16'hFFF9, 16'h2,    16'hFFFF, 1'b0},
    '{3'b101, 32'd100,      32'd7,        32'd14,       16'd100,  16'd7,    16'd14,   1'b0},
    '{3'b111, 32'd100,      32'd7,        32'd2,        16'd100,  16'd7,    16'd2,    1'b0},
    '{3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 16'd5,    16'd0,    16'hFFFF, 1'b1},
    '{3'b111, 32'd5,        32'd0,        32'd5,        16'd5,    16'd0,    16'd5,    1'b1},
    '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 16'h8000, 16'hFFFF, 16'h8000, 1'b1},
    '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h0,        16'h8000, 16'hFFFF, 16'h0,    1'b1}
  };

  function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a,
                                         input logic [31:0] b, input int unsigned wd);
    logic [63:0] m, ua, ub, r;
    logic signed [63:0] sa, sb;
    m  = (64'd1 << wd) - 64'd1;
    ua = {32'd0, a} & m;
    ub = {32'd0, b} & m;
    sa = $signed(ua << (64 - wd)) >>> (64 - wd);
    sb = $signed(ub << (64 - wd)) >>> (64 - wd);
    r  = '0;
    case (f)
      3'b000: r = sa * sb;
      3'b001: r = (sa * sb) >>> wd;
      3'b010: r = (sa * $signed(ub)) >>> wd;
      3'b011: r = (ua * ub) >> wd;
      3'b100: begin
        if (ub == 64'd0) r = m;
        else if (sb == -64'sd1 && ua == (64'd1 << (wd - 1))) r = ua;
        else r = sa / sb;
      end
      3'b101: r = (ub == 64'd0) ? m : ua / ub;
      3'b110: begin
        if (ub == 64'd0) r = ua;
        else if (sb == -64'sd1 && ua == (64'd1 << (wd - 1))) r = 64'd0;
        else r = sa % sb;
      end
      default: r = (ub == 64'd0) ? ua : ua % ub;
    endcase
    return r[31:0] & m[31:0];
  endfunction

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    funct3 = f; op_a = a; op_b = b; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    funct3 = 3'($urandom); op_a = $urandom; op_b = $urandom;
  endtask

  task automatic collect(output logic [31:0] r, output int lat, output bit to);
    to = 1'b1; lat = 0; r = '0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (obs_valid) begin
        lat = i; r = obs_res; to = 1'b0;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (obs_valid !== 1'b0 || obs_res !== 32'h0 || obs_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset cfg%0d got valid=%b result=%h busy=%b exp 0/0/0",
               cfg, obs_valid, obs_res, obs_busy);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (obs_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready cfg%0d got %b exp 1", cfg, obs_ready);
    end
  endtask

  task automatic test_table();
    logic [31:0] r, exp;
    int lat, elat;
    bit to;
    foreach (vecs[i]) begin
      if (w == 32) begin
        issue(vecs[i].f, vecs[i].a32, vecs[i].b32);
        sb_q.push_back(vecs[i].e32);
      end else begin
        issue(vecs[i].f, {16'h0, vecs[i].a16}, {16'h0, vecs[i].b16});
        sb_q.push_back({16'h0, vecs[i].e16});
      end
      collect(r, lat, to);
      exp  = sb_q.pop_front();
      elat = vecs[i].sp ? 1 : int'(nsteps) + 2;
      checks++;
      if (to || r !== exp) begin
        errors++;
        $display("FAIL table%0d cfg%0d result got %h exp %h (timeout=%0d)", i, cfg, r, exp, to);
      end
      checks++;
      if (lat != elat) begin
        errors++;
        $display("FAIL table%0d_latency cfg%0d got %0d exp %0d", i, cfg, lat, elat);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r, exp;
    int lat;
    bit to;
    out_ready = 1'b0;
    issue(3'b000, 32'd3, 32'd5);
    sb_q.push_back(32'd15);
    to = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (obs_valid) begin to = 1'b0; break; end
    end
    checks++;
    if (to) begin
      errors++;
      $display("FAIL hold_wait cfg%0d got no out_valid exp out_valid within 200 cycles", cfg);
    end
    exp = sb_q.pop_front();
    funct3 = 3'b101; op_a = 32'd100; op_b = 32'd7; in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      checks++;
      if (obs_valid !== 1'b1 || obs_res !== exp || obs_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold%0d cfg%0d got valid=%b result=%h in_ready=%b exp 1/%h/0",
                 k, cfg, obs_valid, obs_res, obs_ready, exp);
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    checks++;
    if (obs_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_in_ready cfg%0d got %b exp 1", cfg, obs_ready);
    end
    @(posedge clk);
    sb_q.push_back(32'd14);
    #1;
    in_valid = 1'b0; op_a = $urandom; op_b = $urandom;
    checks++;
    if (obs_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drop cfg%0d got out_valid=%b exp 0", cfg, obs_valid);
    end
    collect(r, lat, to);
    exp = sb_q.pop_front();
    checks++;
    if (to || r !== exp || lat != int'(nsteps) + 2) begin
      errors++;
      $display("FAIL b2b_result cfg%0d got %h lat %0d exp %h lat %0d", cfg, r, lat, exp, nsteps + 2);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r, exp;
    int lat;
    bit to;
    issue(3'b000, 32'h1234, 32'h5);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (obs_valid !== 1'b0 || obs_res !== 32'h0 || obs_busy !== 1'b0) begin
      errors++;
      $display("FAIL async_reset cfg%0d got valid=%b result=%h busy=%b exp 0/0/0",
               cfg, obs_valid, obs_res, obs_busy);
    end
    @(negedge clk);
    rst = 1'b0;
    issue(3'b000, 32'd3, 32'd4);
    sb_q.push_back(32'd12);
    collect(r, lat, to);
    exp = sb_q.pop_front();
    checks++;
    if (to || r !== exp || lat != int'(nsteps) + 2) begin
      errors++;
      $display("FAIL after_reset_mul cfg%0d got %h lat %0d exp %h lat %0d", cfg, r, lat, exp, nsteps + 2);
    end
  endtask

  task automatic test_flush();
    int fc;
    bit seen;
    fc = (nsteps < 5) ? int'(nsteps) : 5;
    issue(3'b000, 32'd7, 32'd9);
    for (int i = 1; i <= fc; i++) @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; funct3 = 3'b000; op_a = 32'd2; op_b = 32'd3;
    #1;
    checks++;
    if (obs_ready !== 1'b0 || obs_busy !== 1'b1) begin
      errors++;
      $display("FAIL flush_in_ready cfg%0d got in_ready=%b busy=%b exp 0/1", cfg, obs_ready, obs_busy);
    end
    @(posedge clk);
    #1;
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if (obs_busy !== 1'b0 || obs_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle cfg%0d got busy=%b valid=%b exp 0/0", cfg, obs_busy, obs_valid);
    end
    seen = 1'b0;
    repeat (nsteps + 4) begin
      @(negedge clk);
      if (obs_valid || obs_busy) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL flush_leak cfg%0d got activity=1 exp 0", cfg);
    end
  endtask

  task automatic test_random();
    logic [2:0]  f;
    logic [31:0] a, b, r, exp;
    int lat, elat;
    bit to, sp;
    for (int n = 0; n < 25; n++) begin
      f = 3'($urandom);
      a = $urandom & mask;
      b = $urandom & mask;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = (mask >> 1) + 32'd1; b = mask; end
        2: b = 32'd1;
        3: b = 32'($urandom_range(1, 15));
        default: ;
      endcase
      sp   = f[2] && (b == 32'd0 || (!f[0] && a == (mask >> 1) + 32'd1 && b == mask));
      elat = sp ? 1 : int'(nsteps) + 2;
      issue(f, a, b);
      sb_q.push_back(ref_op(f, a, b, w));
      collect(r, lat, to);
      exp = sb_q.pop_front();
      checks++;
      if (to || r !== exp || lat != elat) begin
        errors++;
        $display("FAIL random%0d cfg%0d f=%b a=%h b=%h got %h lat %0d exp %h lat %0d",
                 n, cfg, f, a, b, r, lat, exp, elat);
      end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    funct3 = 3'b000; op_a = '0; op_b = '0; cfg = 0;
    for (int c = 0; c < 3; c++) begin
      cfg    = c;
      w      = (c == 0) ? 32 : 16;
      nsteps = (c == 0) ? 32 : (c == 1) ? 8 : 4;
      mask   = (c == 0) ? 32'hFFFFFFFF : 32'h0000FFFF;
      test_reset();
      test_table();
      test_back_to_back();
      test_reset_mid();
      test_flush();
      test_random();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got no completion exp finish before 2000000 ns");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/iter_muldiv_unit.md
Name: iter_muldiv_unit

Overview:
Parametrised iterative multiply/divide execution unit implementing the RV32M funct3 operation set.
- Sits beside the combinational EX-stage ALU; the decoder steers M-extension instructions here.
- Operand width is generalised (XLEN) and throughput is tunable (BITS_PER_CYCLE).
- A valid/ready handshake on both sides lets the pipeline stall on a busy unit and on result backpressure.

Parameters:
- XLEN, 32: operand/result width; must be even and >= 8.
- BITS_PER_CYCLE, 1: multiplier/quotient bits retired per CALC cycle; must be 1, 2 or 4 and divide XLEN.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  request present.
- in_ready  out  1  unit can accept a request this cycle.
- funct3  in  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op_a  in  XLEN  rs1 operand (multiplicand / dividend).
- op_b  in  XLEN  rs2 operand (multiplier / divisor).
- flush  in  1  kill the in-flight op (branch mispredict / trap).
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- result  out  XLEN  op result.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE.
  - out_valid=0, result=0, busy=0.
  - in_ready=1 once rst deasserts.
  - All internal accumulators are cleared.
- States: IDLE, CALC, FIX, DONE.
- Accept condition:
  - Handshake = in_valid & in_ready.
  - in_ready = (state==IDLE) | (state==DONE & out_ready), which allows back-to-back ops.
  - funct3, op_a and op_b are sampled at the handshake edge; later changes on these inputs are ignored.
- On handshake:
  - Record the operand signs: op_a signed for MUL/MULH/MULHSU/DIV/REM; op_b signed for MUL/MULH/DIV/REM.
  - Load the magnitudes |a| and |b|.
  - Clear the step counter and go to CALC.
- Special divide cases bypass CALC and go straight to DONE; out_valid is asserted the cycle after the handshake:
  - Divide by zero (op_b==0): DIV/DIVU give all-ones; REM/REMU give op_a.
  - Signed overflow (DIV/REM, op_a=100..0, op_b=all-ones): DIV gives op_a; REM gives 0.
- CALC:
  - Runs N = XLEN/BITS_PER_CYCLE cycles; the counter is ceil(log2(N+1)) bits.
  - Multiply: shift-add on a 2*XLEN-bit product register.
  - Divide: restoring shift-subtract producing XLEN-bit quotient and remainder.
  - After the Nth cycle, go to FIX.
- FIX (1 cycle), sign correction:
  - Product: negated if sign_a^sign_b.
  - Quotient: negated if sign_a^sign_b.
  - Remainder: takes the sign of the dividend.
  - Result selection: MUL takes product[XLEN-1:0]; MULH/MULHSU/MULHU take product[2XLEN-1:XLEN]; DIV/DIVU take the quotient; REM/REMU take the remainder.
  - result is registered, then go to DONE.
- Latency (handshake cycle = cycle 0): out_valid=1 in cycle N+2 for normal ops, cycle 1 for special cases.
- DONE:
  - out_valid=1, and result holds stable until out_ready=1.
  - Out handshake without a new in-handshake: go to IDLE, out_valid=0 next cycle.
  - Out handshake with a new in-handshake in the same cycle: start the new op; out_valid=0 next cycle.
- flush:
  - Any state other than IDLE returns to IDLE on the next edge, with out_valid=0 and no result delivered.
  - flush has priority over a simultaneous in-handshake, which is dropped; in_ready is forced to 0 while flush=1.
- busy=0 only in IDLE.
- Reset asserted mid-operation aborts immediately and asynchronously.
- All arithmetic is modulo 2^XLEN, except for the MULH* high halves.

Test Plan:
- Multiply, XLEN=32, BITS_PER_CYCLE=1.
  - MUL 7 x 0xFFFFFFFD gives 0xFFFFFFEB, with out_valid exactly 34 cycles after the handshake.
  - MULHU 0xFFFFFFFF x 0xFFFFFFFF gives 0xFFFFFFFE.
  - MULH 0x80000000 x 0x80000000 gives 0x40000000.
  - MULHSU 0xFFFFFFFF x 2 gives 0xFFFFFFFF.
- Divide and remainder.
  - DIV 0xFFFFFFF9 / 2 gives 0xFFFFFFFD; REM of the same gives 0xFFFFFFFF.
  - DIVU 100 / 7 gives 14; REMU of the same gives 2.
- Special cases.
  - DIV 5/0 gives 0xFFFFFFFF and REMU 5/0 gives 5, both with out_valid in cycle 1.
  - DIV 0x80000000/0xFFFFFFFF gives 0x80000000; REM of the same gives 0.
- Handshake.
  - Hold out_ready=0 for 10 cycles in DONE: result stays stable and in_ready stays 0.
  - Then raise out_ready together with in_valid: the new op is accepted the same cycle and out_valid drops next cycle.
- Flush and reset.
  - Assert flush in CALC cycle 5: IDLE next cycle and no out_valid for that op.
  - Assert rst in CALC: outputs are 0 immediately; a subsequent MUL 3x4 gives 12.
- Parameter sweep.
  - Rerun the scenarios above at XLEN=16 with BITS_PER_CYCLE=2 and 4 (latencies 10 and 6).
  - Include MUL 0x00FF x 0x0101 giving 0xFFFF.
  - Run random ops against a reference model.
